// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: collects SPI payload bytes into a shadow bank and commits the
// bank to cfg_out_o only after a complete, valid frame. A truncated, aborted or
// corrupted frame never touches the live configuration.
// Optional build macro: CHECKSUM_EN. When defined, byte NB is an XOR checksum over
// bytes 0..NB-1, frames need NB+1 bytes, and err_sum_o counts checksum rejects.
// NB must stay below 31 so the byte index can address every payload byte.
module spi_frame_ctrl #(
  parameter int unsigned NB = 14,
  parameter int unsigned CW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            frame_start_i,
  input  logic            frame_end_i,
  input  logic            byte_valid_i,
  input  logic [7:0]      byte_data_i,
  output logic [NB*8-1:0] cfg_out_o,
  output logic            commit_o,
  output logic [4:0]      byte_idx_o,
  output logic            busy_o,
  output logic [CW-1:0]   err_len_o,
  output logic [CW-1:0]   err_sum_o
);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck, StCommit} state_e;

  localparam logic [4:0]    NbIdx  = 5'(NB);
  localparam logic [4:0]    IdxMax = 5'd31;
  localparam logic [CW-1:0] CntMax = {CW{1'b1}};
`ifdef CHECKSUM_EN
  localparam logic [4:0]    MinLen = 5'(NB + 1);
`else
  localparam logic [4:0]    MinLen = 5'(NB);
`endif

  state_e          state_q;
  logic [NB*8-1:0] shadow_q;
  logic [NB*8-1:0] cfg_q;
  logic [4:0]      idx_q;
  logic            commit_q;
  logic            pending_q;
  logic [CW-1:0]   err_len_q;
`ifdef CHECKSUM_EN
  logic [7:0]      xor_q;
  logic [CW-1:0]   err_sum_q;
`endif

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == CntMax) ? v : v + 1'b1;
  endfunction

  // Frame sequencer: byte capture, length/checksum check, atomic commit.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      shadow_q  <= '0;
      cfg_q     <= '0;
      idx_q     <= '0;
      commit_q  <= 1'b0;
      pending_q <= 1'b0;
      err_len_q <= '0;
`ifdef CHECKSUM_EN
      xor_q     <= '0;
      err_sum_q <= '0;
`endif
    end else begin
      commit_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (frame_start_i || pending_q) begin
            state_q   <= StRecv;
            idx_q     <= '0;
            pending_q <= 1'b0;
`ifdef CHECKSUM_EN
            xor_q     <= '0;
`endif
          end
        end
        StRecv: begin
          // An abort (start without end) discards any byte arriving with it.
          if (byte_valid_i && !(frame_start_i && !frame_end_i)) begin
            if (idx_q < NbIdx) begin
              shadow_q[8*int'(idx_q) +: 8] <= byte_data_i;
            end
`ifdef CHECKSUM_EN
            if (idx_q <= NbIdx) begin
              xor_q <= xor_q ^ byte_data_i;
            end
`endif
            if (idx_q != IdxMax) begin
              idx_q <= idx_q + 5'd1;
            end
          end
          if (frame_end_i) begin
            state_q <= StCheck;
          end else if (frame_start_i) begin
            err_len_q <= sat_inc(err_len_q);
            idx_q     <= '0;
`ifdef CHECKSUM_EN
            xor_q     <= '0;
`endif
          end
        end
        StCheck: begin
          state_q <= StIdle;
          if (idx_q < MinLen) begin
            err_len_q <= sat_inc(err_len_q);
`ifdef CHECKSUM_EN
          end else if (xor_q != 8'h00) begin
            err_sum_q <= sat_inc(err_sum_q);
`endif
          end else begin
            state_q <= StCommit;
          end
          if (frame_start_i) begin
            pending_q <= 1'b1;
          end
        end
        StCommit: begin
          cfg_q    <= shadow_q;
          commit_q <= 1'b1;
          state_q  <= StIdle;
          if (frame_start_i) begin
            pending_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cfg_out_o  = cfg_q;
  assign commit_o   = commit_q;
  assign byte_idx_o = idx_q;
  assign err_len_o  = err_len_q;
  // A latched start keeps busy asserted across the one IDLE cycle before RECV.
  assign busy_o     = (state_q != StIdle) | pending_q;
`ifdef CHECKSUM_EN
  assign err_sum_o  = err_sum_q;
`else
  assign err_sum_o  = '0;
`endif

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Testbench for spi_frame_ctrl: directed frames, scoreboard of expected commits.
// Adapts to the CHECKSUM_EN build by inserting a checksum byte at index NB.
module tb_spi_frame_ctrl;

  localparam int unsigned NB = 14;
  localparam int unsigned CW = 8;
`ifdef CHECKSUM_EN
  localparam int Extra = 1;
  localparam bit Chk = 1'b1;
`else
  localparam int Extra = 0;
  localparam bit Chk = 1'b0;
`endif

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            frame_start_i;
  logic            frame_end_i;
  logic            byte_valid_i;
  logic [7:0]      byte_data_i;
  logic [NB*8-1:0] cfg_out_o;
  logic            commit_o;
  logic [4:0]      byte_idx_o;
  logic            busy_o;
  logic [CW-1:0]   err_len_o;
  logic [CW-1:0]   err_sum_o;

  spi_frame_ctrl #(.NB(NB), .CW(CW)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .frame_start_i (frame_start_i),
    .frame_end_i   (frame_end_i),
    .byte_valid_i  (byte_valid_i),
    .byte_data_i   (byte_data_i),
    .cfg_out_o     (cfg_out_o),
    .commit_o      (commit_o),
    .byte_idx_o    (byte_idx_o),
    .busy_o        (busy_o),
    .err_len_o     (err_len_o),
    .err_sum_o     (err_sum_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  logic [NB*8-1:0] exp_q [$];
  logic [NB*8-1:0] cfg_model = '0;
  int              exp_err_len = 0;
  int              exp_err_sum = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_start();
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid_i = 1'b1;
    byte_data_i  = b;
    step();
    byte_valid_i = 1'b0;
    step();
  endtask

  // One frame: optional aborted prefix, len bytes, frame_end, then 5 observed cycles.
  task automatic run_frame(input int len, input logic [7:0] base, input bit bad,
                           input bit coinc, input int abort_n, input bit no_start,
                           input bit chain);
    logic [7:0]      d [32];
    logic [7:0]      x;
    logic [NB*8-1:0] e;
    logic [NB*8-1:0] cap;
    bit              pass;
    int              seen;
    int              at;
    int              n_sep;
    cap  = '0;
    seen = 0;
    at   = -1;
    x    = 8'h00;
    for (int i = 0; i < 32; i++) d[i] = 8'(base + 8'(i));
    if (Chk && len > int'(NB)) begin
      for (int k = 0; k < int'(NB); k++) x = x ^ d[k];
      d[NB] = bad ? ((x == 8'h00) ? 8'hFF : 8'h00) : x;
    end
    pass = (len >= int'(NB) + Extra) && !(Chk && bad);
    e = '0;
    for (int k = 0; k < int'(NB); k++) e[8*k +: 8] = d[k];

    if (!no_start) pulse_start();
    if (abort_n > 0) begin
      for (int i = 0; i < abort_n; i++) send_byte(8'hEE);
      exp_err_len = sat(exp_err_len);
      pulse_start();
    end
    n_sep = (coinc && len > 0) ? len - 1 : len;
    for (int i = 0; i < n_sep; i++) send_byte(d[i]);

    frame_end_i = 1'b1;
    if (coinc && len > 0) begin
      byte_valid_i = 1'b1;
      byte_data_i  = d[len-1];
    end
    if (pass) exp_q.push_back(e);
    else if (len < int'(NB) + Extra) exp_err_len = sat(exp_err_len);
    else exp_err_sum = sat(exp_err_sum);

    for (int i = 0; i < 5; i++) begin
      step();
      frame_end_i  = 1'b0;
      byte_valid_i = 1'b0;
      if (chain && i == 1) frame_start_i = 1'b1;
      if (chain && i == 2) frame_start_i = 1'b0;
      @(negedge clk_i);
      if (commit_o === 1'b1) begin
        seen++;
        at  = i;
        cap = cfg_out_o;
      end
      if (chain && i == 2) begin
        chk("busy_pending", busy_o, 1'b1);
        chk("idx_hold_pending", byte_idx_o, (len > 31) ? 31 : len);
      end
      if (chain && i == 3) begin
        chk("busy_recv_after_pending", busy_o, 1'b1);
        chk("idx_reset_after_pending", byte_idx_o, 0);
      end
    end

    if (pass) begin
      e = exp_q.pop_front();
      chk("commit_count", seen, 1);
      chk("commit_latency", at, 2);
      chk("cfg_at_commit", cap, e);
      cfg_model = e;
    end else begin
      chk("no_commit", seen, 0);
    end
    chk("cfg_out", cfg_out_o, cfg_model);
    chk("err_len", err_len_o, exp_err_len);
    chk("err_sum", err_sum_o, exp_err_sum);
    if (chain) begin
      chk("byte_idx_chain", byte_idx_o, 0);
    end else begin
      chk("byte_idx", byte_idx_o, (len > 31) ? 31 : len);
      chk("busy_idle", busy_o, 1'b0);
    end
  endtask

  initial begin
    rst_ni        = 1'b0;
    frame_start_i = 1'b0;
    frame_end_i   = 1'b0;
    byte_valid_i  = 1'b0;
    byte_data_i   = 8'h00;
    repeat (3) step();
    @(negedge clk_i);
    chk("rst_cfg", cfg_out_o, '0);
    chk("rst_commit", commit_o, 1'b0);
    chk("rst_idx", byte_idx_o, 0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_err_len", err_len_o, 0);
    chk("rst_err_sum", err_sum_o, 0);
    rst_ni = 1'b1;
    step();

    // Full frame 0x01..0x0E (plus checksum 0x0F when enabled).
    run_frame(int'(NB) + Extra, 8'h01, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("cfg_byte0", cfg_out_o[7:0], 8'h01);
    chk("cfg_byte13", cfg_out_o[8*13 +: 8], 8'h0E);

    // 13-byte frame is rejected for length; cfg_out untouched.
    run_frame(13, 8'h20, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // 20-byte frame commits first NB bytes; index counts all 20.
    run_frame(20, 8'h40, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    // Corrupted checksum (only rejected in the checksum build).
    run_frame(int'(NB) + Extra, 8'h01, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    // Mid-frame abort after 5 bytes, then a valid frame.
    run_frame(int'(NB) + Extra, 8'h90, 1'b0, 1'b0, 5, 1'b0, 1'b0);
    // Last byte coincident with frame_end.
    run_frame(int'(NB) + Extra, 8'hA0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    // frame_start during COMMIT, then the follow-on frame without its own start.
    run_frame(int'(NB) + Extra, 8'h60, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    run_frame(int'(NB) + Extra, 8'hC0, 1'b0, 1'b0, 0, 1'b1, 1'b0);

    // Reset in RECV after 7 bytes.
    pulse_start();
    for (int i = 0; i < 7; i++) send_byte(8'(8'h30 + 8'(i)));
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    @(negedge clk_i);
    cfg_model   = '0;
    exp_err_len = 0;
    exp_err_sum = 0;
    chk("midrst_cfg", cfg_out_o, '0);
    chk("midrst_idx", byte_idx_o, 0);
    chk("midrst_busy", busy_o, 1'b0);
    chk("midrst_err_len", err_len_o, 0);
    chk("midrst_err_sum", err_sum_o, 0);
    chk("midrst_commit", commit_o, 1'b0);

    // 300 empty frames: err_len saturates.
    step();
    for (int n = 0; n < 300; n++) begin
      pulse_start();
      frame_end_i = 1'b1;
      step();
      frame_end_i = 1'b0;
      step();
      if (n == 253) begin
        @(negedge clk_i);
        chk("err_len_254", err_len_o, 254);
      end
    end
    step();
    @(negedge clk_i);
    chk("err_len_sat", err_len_o, 255);
    chk("sat_err_sum", err_sum_o, 0);
    chk("sat_cfg", cfg_out_o, '0);
    chk("sat_busy", busy_o, 1'b0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
- Sequences the byte stream from the SPI shifter into a shadow register bank. Commits that bank atomically to the live configuration bus only after a complete, valid frame.
- Sits between the SPI byte shifter and the stepgen/PWM/dout/wdt consumers.
- Stops a truncated or corrupted transfer from partially updating velocities or outputs.
- Exports the running byte index that the readback mux uses to select transmit data.

Parameters:
NB, 14, number of payload bytes per frame committed to cfg_out
CW, 8, width of the saturating error counters

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous reset, active low
frame_start  input  1  one-cycle pulse, SSEL falling edge (already synchronised)
frame_end  input  1  one-cycle pulse, SSEL rising edge (already synchronised)
byte_valid  input  1  one-cycle pulse, byte_data holds a complete received byte
byte_data  input  8  received byte
cfg_out  output  NB*8  live configuration; byte k occupies bits [8k+7:8k]
commit  output  1  one-cycle pulse when cfg_out is updated
byte_idx  output  5  index of the next byte to be received, saturating at 31
busy  output  1  high in any state other than IDLE
err_len  output  CW  count of frames rejected for short length or abort
err_sum  output  CW  count of frames rejected for checksum; constant 0 without CHECKSUM_EN

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge, including mid-frame):
  - state=IDLE; cfg_out, shadow, running XOR, byte_idx, err_len and err_sum all 0.
  - commit=0, busy=0, pending-start flag cleared.
- States: IDLE, RECV, CHECK, COMMIT.
- IDLE:
  - frame_start or the pending flag -> RECV; byte_idx<=0, xor<=0, pending<=0.
  - byte_valid is ignored.
- RECV, on byte_valid:
  - If byte_idx<NB: shadow[byte_idx]<=byte_data.
  - If byte_idx<=NB: xor<=xor^byte_data.
  - byte_idx<=byte_idx+1, saturating at 31.
  - Bytes beyond NB (or NB+1) are counted only.
- RECV, byte_valid together with frame_end in the same cycle: the byte is accepted first, then -> CHECK with the updated count.
- RECV, frame_start without frame_end: abort the partial frame.
  - err_len++ (saturating).
  - byte_idx<=0, xor<=0; stay in RECV.
  - Shadow contents are kept but never committed unless a later frame passes.
- RECV, frame_start and frame_end in the same cycle: frame_end wins, frame_start is dropped.
- CHECK (exactly 1 cycle), pass rule:
  - Without CHECKSUM_EN: byte count >= NB.
  - With CHECKSUM_EN: count >= NB+1 and xor==0, i.e. byte NB is the XOR of bytes 0..NB-1.
  - Pass -> COMMIT.
  - Length fail -> err_len++ -> IDLE.
  - Length ok but checksum fail -> err_sum++ -> IDLE.
- COMMIT (1 cycle): cfg_out<=shadow, commit=1 during this cycle only -> IDLE.
- Latency: frame_end sampled at edge t -> CHECK at t+1 -> cfg_out and commit valid after edge t+2.
- frame_start arriving in CHECK or COMMIT sets pending. IDLE then enters RECV on the next edge, so no frame is lost.
- byte_valid in CHECK or COMMIT is ignored.
- Counters saturate at 2^CW-1 and never wrap.
- byte_idx holds its value in IDLE/CHECK/COMMIT, so readback keeps the last index until the next frame_start.

Optional Feature:
CHECKSUM_EN
- Defined:
  - Frame length is NB+1; byte NB is the XOR checksum.
  - err_sum is active; both the length and xor checks apply.
- Undefined:
  - No checksum logic; the xor register is removed.
  - err_sum is tied to 0; any frame with >= NB bytes commits.
  - Extra bytes are ignored.

Test Plan:
- NB=14, no EN: frame_start, 14 bytes 0x01..0x0E, frame_end -> commit 1 cycle at t+2; cfg_out byte0=0x01, byte13=0x0E; err_len=0.
- NB=14, no EN: frame of 13 bytes -> no commit, cfg_out unchanged, err_len=1; then a 20-byte frame -> commit with bytes 0..13, byte_idx=20.
- CHECKSUM_EN: 14 bytes 0x01..0x0E plus checksum 0x0F (XOR of 0x01..0x0E) -> commit. Same frame with checksum 0x00 -> no commit, err_sum=1, err_len=0.
- Mid-frame abort: 5 bytes, then frame_start, then a full valid frame -> err_len=1, single commit with the second frame's data only.
- Boundaries:
  - Last byte_valid coincident with frame_end -> counted, commit.
  - frame_start during COMMIT -> busy stays high, RECV entered 2 cycles later, next frame commits.
- Reset: rst_n=0 during RECV after 7 bytes -> next cycle cfg_out=0, byte_idx=0, busy=0, counters 0. Force 300 short frames -> err_len saturates at 255.
